// File: rtl/panel_ctrl.sv
// panel_ctrl: conditions the raw run switch and step button of the control
// panel. Each input is synchronized and debounced. The debounced run level
// drives `change`. A debounced step press becomes a single `step` pulse while
// the processor is stopped, or a `step_rej` pulse while it is running.
module panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int STEP_CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_raw,
  input  logic                  step_raw,
  output logic                  change,
  output logic                  step,
  output logic                  step_rej,
  output logic [STEP_CNT_W-1:0] step_cnt
);

  // Lane indices into the per-input synchronizer/debouncer arrays.
  localparam int RUN = 0;
  localparam int STP = 1;

  // Counter value on which a persisting mismatch is accepted as the new level.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]            s1_q, s2_q;
  logic [1:0]            stable_q, stable_d;
  logic [CNT_W-1:0]      db_cnt_q [2];
  logic [CNT_W-1:0]      db_cnt_d [2];
  logic                  step_prev_q;
  logic                  step_q, step_d;
  logic                  rej_q, rej_d;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic                  step_rise;

  // Two-flop synchronizer for both asynchronous panel inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let s2_q take the old s1_q, which is
      // exactly the two-stage shift; blocking would collapse it into one flop.
      s1_q <= {step_raw, run_raw};
      s2_q <= s1_q;
    end
  end

  // Debounce: a stable value flips only after DEBOUNCE_CYCLES consecutive
  // mismatching samples. Any matching sample restarts the window.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave one
    // unassigned and infer a latch.
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        stable_d[i] = s2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '0;
      // NOTE: this is a two-entry flop array, not a RAM, so it is reset like
      // any other register. Otherwise a stale count could qualify a bounce.
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Step decision: a rising step level is accepted only while stopped.
  // The run level used is the one held during the step_rise cycle.
  always_comb begin
    step_rise  = stable_q[STP] & ~step_prev_q;
    step_d     = step_rise & ~stable_q[RUN];
    rej_d      = step_rise &  stable_q[RUN];
    step_cnt_d = step_cnt_q + STEP_CNT_W'(step_d);
  end

  // Edge-detect register, the one-cycle pulses and the wrapping step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_prev_q <= 1'b0;
      step_q      <= 1'b0;
      rej_q       <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      step_prev_q <= stable_q[STP];
      step_q      <= step_d;
      rej_q       <= rej_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  assign change   = stable_q[RUN];
  assign step     = step_q;
  assign step_rej = rej_q;
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_panel_ctrl.sv
// Self-checking bench for panel_ctrl.
// Stimulus drives the raw inputs. A reference model queues the expected
// change edges and step/step_rej pulses, each tagged with its clock edge.
// A separate monitor pops the queue whenever the DUT shows an event.
module tb_panel_ctrl;

  localparam int DB  = 4;
  localparam int CW  = 5;
  localparam int SCW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           run_raw = 1'b1;
  logic           step_raw = 1'b1;
  logic           change, step, step_rej;
  logic [SCW-1:0] step_cnt;

  panel_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CW),
    .STEP_CNT_W     (SCW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run_raw (run_raw),
    .step_raw(step_raw),
    .change  (change),
    .step    (step),
    .step_rej(step_rej),
    .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit accept; int cnt; int edge_no; } step_exp_t;
  typedef struct { bit level; int edge_no; } chg_exp_t;

  step_exp_t step_sb[$];
  chg_exp_t  chg_sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event with no expected entry (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Each sampled raw value is shifted into a history vector (bit 0 = newest).
  // A stable level flips when the D samples seen by the debouncer all differ
  // from it. The debouncer sees samples two edges old, i.e. bits [DB+1:2].
  // A rising step level is decided on the following edge, using the run
  // level held at that time. Accepted presses bump a counter modulo 2**SCW.
  bit [DB+1:0] hr, hs;
  bit          m_run, m_step, press_pending;
  int          m_cnt;
  int          edge_n = 0;

  initial begin
    hr = '0; hs = '0; m_run = 0; m_step = 0; press_pending = 0; m_cnt = 0;
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        hr = '0; hs = '0; m_run = 0; m_step = 0; press_pending = 0; m_cnt = 0;
      end else begin
        if (press_pending) begin
          press_pending = 0;
          if (!m_run) begin
            m_cnt = (m_cnt + 1) % (1 << SCW);
            step_sb.push_back('{1'b1, m_cnt, edge_n});
          end else begin
            step_sb.push_back('{1'b0, m_cnt, edge_n});
          end
        end
        hr = {hr[DB:0], run_raw};
        hs = {hs[DB:0], step_raw};
        if (hr[DB+1:2] == {DB{~m_run}}) begin
          m_run = ~m_run;
          chg_sb.push_back('{m_run, edge_n});
        end
        if (hs[DB+1:2] == {DB{~m_step}}) begin
          m_step = ~m_step;
          if (m_step) press_pending = 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic last_chg = 1'b0;

  initial begin
    step_exp_t se;
    chg_exp_t  ce;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs", {change, step, step_rej, step_cnt}, '0);
        last_chg = 1'b0;
      end else begin
        check("step_cnt", step_cnt, m_cnt);
        if (step || step_rej) begin
          if (step_sb.size() == 0) begin
            fail_now("unexpected_pulse");
          end else begin
            se = step_sb.pop_front();
            check("pulse_step",     step,     se.accept);
            check("pulse_step_rej", step_rej, !se.accept);
            check("pulse_edge",     edge_n,   se.edge_no);
            check("pulse_cnt",      step_cnt, se.cnt);
          end
        end
        if (change !== last_chg) begin
          if (chg_sb.size() == 0) begin
            fail_now("unexpected_change");
          end else begin
            ce = chg_sb.pop_front();
            check("change_level", change, ce.level);
            check("change_edge",  edge_n, ce.edge_no);
          end
          last_chg = change;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 2 time units after a rising edge and hold for n edges.
  task automatic hold(input logic r, input logic s, input int n);
    @(posedge clk); #2;
    run_raw  = r;
    step_raw = s;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    // Reset held with both inputs high, then released.
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    hold(0, 0, 20);

    // Clean run toggle.
    hold(1, 0, 15);
    hold(0, 0, 15);

    // Bounce rejection: two-cycle levels, then a steady high.
    hold(1, 0, 2); hold(0, 0, 2); hold(1, 0, 2); hold(0, 0, 2);
    hold(1, 0, 15);
    hold(0, 0, 15);

    // Step while stopped: three presses.
    for (int i = 0; i < 3; i++) begin
      hold(0, 1, 20);
      hold(0, 0, 20);
    end

    // Step while running.
    hold(1, 0, 15);
    hold(1, 1, 20);
    hold(1, 0, 20);

    // Run falls as step rises: the running level is used, so rejected.
    hold(1, 1, 1);
    hold(0, 1, 19);
    hold(0, 0, 20);

    // Run rises as step rises: the stopped level is used, so accepted.
    hold(0, 1, 1);
    hold(1, 1, 19);
    hold(1, 0, 20);
    hold(0, 0, 20);

    // Counter wrap from a fresh reset: five accepted presses.
    apply_reset(3);
    for (int i = 0; i < 5; i++) begin
      hold(0, 1, 12);
      hold(0, 0, 12);
    end

    // Reset during a held press: no pulse until a new press.
    hold(0, 1, 2);
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 step_raw = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    hold(0, 0, 15);
    hold(0, 1, 12);
    hold(0, 0, 12);

    // Randomized bouncy activity on both inputs.
    for (int i = 0; i < 60; i++) begin
      hold(1'($urandom), 1'($urandom), $urandom_range(1, 12));
    end
    hold(0, 0, 30);

    check("step_queue_drained",   step_sb.size(), 0);
    check("change_queue_drained", chg_sb.size(),  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/panel_ctrl.md
Name: panel_ctrl

Overview:
- Front-end conditioner for the processor control panel.
- Takes the raw, asynchronous run switch and step push-button and produces clean, synchronous control signals for the run/step controller that drives the processor's `work` enable:
  - `change`: a debounced run level.
  - `step`: a single-cycle step request.
- Also reports rejected step presses and keeps a wrapping count of accepted steps for debug.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized input must differ from its stable value before the stable value flips; legal range 1..2**CNT_W-1.
- CNT_W, 5: width of each debounce counter.
- STEP_CNT_W, 8: width of the accepted-step counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- run_raw  input  1  raw run switch; asynchronous to clk, may bounce.
- step_raw  input  1  raw step button; asynchronous to clk, may bounce.
- change  output  1  debounced run level; 1 = run, 0 = stop.
- step  output  1  one-cycle step request, issued only while stopped.
- step_rej  output  1  one-cycle flag: step press arrived while running and was dropped.
- step_cnt  output  STEP_CNT_W  number of accepted step pulses, modulo 2**STEP_CNT_W.

Behaviour:
- Reset (async, rst=1):
  - All synchronizer flops, stable values, counters and edge registers go to 0.
  - Outputs: change=0, step=0, step_rej=0, step_cnt=0.
  - Reset asserted mid-debounce or mid-pulse aborts immediately; no pulse is issued after release until a fresh qualified edge occurs.
- Synchronizer: each raw input passes through two flops (s1, s2). The debouncer sees s2 only.
- Debouncer (identical per input, independent counters):
  - s2 == stable: counter <= 0.
  - s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
  - otherwise: counter <= counter+1.
  - Any cycle where s2 returns to stable resets the count, so a bounce restarts the qualification window.
- Latency, raw input held steady from edge E0 (first sampling edge): stable flips at edge E0+1+DEBOUNCE_CYCLES.
- change: equal to the run stable value (a registered flop, no extra delay). Falling run behaves symmetrically.
- Step edge: step_rise = step stable 0->1, detected with a one-cycle delayed copy of the stable value. The release edge produces nothing.
- At the edge after step_rise:
  - If change==0 in the step_rise cycle: step=1 for exactly one cycle, and step_cnt increments in the same cycle.
  - Else: step_rej=1 for exactly one cycle, and step_cnt is unchanged.
- Simultaneous events: when step_rise and a run-stable flip occur on the same edge, the decision uses change as it was before that edge.
  - Running->stopping with step_rise in the same cycle: rejected.
  - Stopped->starting with step_rise in the same cycle: accepted.
- step and step_rej are never both 1. At most one step pulse per press, regardless of hold length.
- A new pulse requires the step stable value to return to 0 and re-qualify. Minimum press-to-press spacing is 2*DEBOUNCE_CYCLES cycles.
- step_cnt wraps 2**STEP_CNT_W-1 -> 0 with no flag.
- DEBOUNCE_CYCLES=1: stable follows s2 with one cycle delay; no filtering.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 with run_raw=1 and step_raw=1; release.
  - Required: all outputs stay 0 during reset; change rises exactly 1+DEBOUNCE_CYCLES edges after first sampling post-release; step fires once if change was still 0 at step_rise, else step_rej fires.
- Clean run toggle (DEBOUNCE_CYCLES=4):
  - Stimulus: run_raw 0->1 held.
  - Required: change=1 at edge E0+5. Then run_raw 1->0 gives change=0 at E0'+5.
- Bounce rejection (DEBOUNCE_CYCLES=4):
  - Stimulus: run_raw toggles 1,0,1,0 with 2-cycle periods, then held 1.
  - Required: change stays 0 through the bounce and rises 5 edges after the final steady value is sampled.
- Step while stopped:
  - Stimulus: change=0; three separate presses of 20 cycles each, gaps of 20 cycles.
  - Required: exactly three one-cycle step pulses; step_cnt reads 1, 2, 3; step_rej never asserts.
- Step while running:
  - Stimulus: change=1; one press.
  - Required: step stays 0, step_rej pulses once, step_cnt unchanged.
  - Also: same-cycle step_rise with change falling 1->0 gives rejected.
- Counter wrap (STEP_CNT_W=2):
  - Stimulus: 5 accepted presses.
  - Required: step_cnt sequence 1, 2, 3, 0, 1.
  - Also: reset asserted during a held press gives no pulse after release until a new press.
